// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_pkg
// Brief    : Shared widths and the fetch buffer entry type for the RV32I front end.
// Revision : 1.0 - initial release
// ============================================================================
package rv_fetch_pkg;

    localparam int              XLEN    = 32;
    localparam int              ILEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] istr;
        logic [XLEN-1:0] pc;
        logic            misalign;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_fifo
// Brief    : Synchronous FIFO with flush; head is read straight from storage.
// Revision : 1.0 - initial release
// ============================================================================
module rv_fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);

    T                r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + {c_AW'(0), w_push} - {c_AW'(0), w_pop};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rv_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv_ifetch_unit
// Brief    : RV32I fetch front end: PC, credit-limited requests, response buffer,
//            redirect flush. FETCH_ALIGN_CHECK_EN adds the out_misalign port.
// Revision : 1.0 - initial release
// ============================================================================
module rv_ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_istr,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic            out_misalign,
`endif
    output logic [XLEN-1:0] out_pc
);

    localparam int            c_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int            c_DW      = c_CW + 6;
    localparam logic [c_CW:0] c_CREDITS = (c_CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [c_DW-1:0] r_drop;
    logic [c_CW-1:0] w_fifo_count;
    logic [c_CW-1:0] w_outstanding;
    logic [c_CW:0]   w_in_use;
    logic [XLEN-1:0] w_tag_pc;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_rsp_discard;
    logic            w_out_fire;
    logic            w_push_mis;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Every buffered or in-flight fetch holds a credit, so a response always finds room.
    assign w_in_use      = {1'b0, w_fifo_count} + {1'b0, w_outstanding};
    assign mem_req_valid = !reset && !redirect_valid && (w_in_use < c_CREDITS);
    assign mem_req_addr  = r_pc;

    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign w_out_fire    = out_valid && out_ready;
    // A response coinciding with a redirect is always from the old stream.
    assign w_rsp_discard = mem_rsp_valid && ((r_drop != '0) || redirect_valid);
    assign w_rsp_keep    = mem_rsp_valid && (r_drop == '0) && !redirect_valid;

    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_drop <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= w_redirect_target;
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_STEP;
            end
            r_drop <= r_drop + (redirect_valid ? c_DW'(w_outstanding) : c_DW'(0))
                      - c_DW'(w_rsp_discard);
        end
    end

    // Tag queue occupancy is the outstanding-request count; a redirect hands it to r_drop.
    rv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [XLEN-1:0])
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_req_fire),
        .push_data (r_pc),
        .pop       (w_rsp_keep),
        .head      (w_tag_pc),
        .count     (w_outstanding)
    );

    assign w_push_entry = '{istr: mem_rsp_data, pc: w_tag_pc, misalign: w_push_mis};

    rv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_push_entry),
        .pop       (w_out_fire),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign out_valid = (w_fifo_count != '0);
    assign out_istr  = w_head.istr;
    assign out_pc    = w_head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_mis_pend;

    // The flag rides on the first instruction of the redirected stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_mis_pend <= (redirect_pc[1:0] != 2'b00);
        end else if (w_rsp_keep) begin
            r_mis_pend <= 1'b0;
        end
    end

    assign w_push_mis   = r_mis_pend;
    assign out_misalign = out_valid && w_head.misalign;
`else
    logic w_unused_align;

    assign w_push_mis     = 1'b0;
    assign w_unused_align = w_head.misalign ^ (^redirect_pc[1:0]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_ifetch_unit
// Brief    : Self-checking bench: directed table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_ifetch_unit;

    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] c_XOR      = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_istr, out_pc;
    logic        out_misalign;

    logic        d2_req_valid, d2_rsp_valid, d2_out_valid;
    logic [31:0] d2_addr, d2_rsp_data, d2_out_istr, d2_out_pc;
    logic        d2_misalign;

    rv_ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_istr(out_istr),
`ifdef FETCH_ALIGN_CHECK_EN
        .out_misalign(out_misalign),
`endif
        .out_pc(out_pc)
    );

    rv_ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(FIFO_DEPTH)) dut_wrap (
        .clk(clk), .reset(reset),
        .mem_req_valid(d2_req_valid), .mem_req_ready(1'b1), .mem_req_addr(d2_addr),
        .mem_rsp_valid(d2_rsp_valid), .mem_rsp_data(d2_rsp_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(d2_out_valid), .out_ready(1'b1), .out_istr(d2_out_istr),
`ifdef FETCH_ALIGN_CHECK_EN
        .out_misalign(d2_misalign),
`endif
        .out_pc(d2_out_pc)
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign out_misalign = 1'b0;
    assign d2_misalign  = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] istr; logic [31:0] pc; bit mis; } ent_t;
    typedef struct { bit ordy; bit exp_rv; logic [31:0] exp_addr; bit exp_ov; logic [31:0] exp_opc; } vec_t;

    mreq_t       memq[$];
    infl_t       m_infl[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc;
    bit          m_mis_pend;
    int          cyc, last_due, mem_lat;
    bit          rand_lat;
    bit          d2_pend;
    logic [31:0] d2_addrs[$];

    logic        s_rv, s_ov, s_mis;
    logic [31:0] s_addr, s_opc, s_oistr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        d2_rsp_valid = 1'b0; d2_rsp_data = 32'h13;
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_istr", out_istr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_wrap_addr", d2_addr, 32'hFFFF_FFF8);
        reset = 1'b0;
        memq.delete(); m_infl.delete(); m_fifo.delete(); d2_addrs.delete();
        m_pc = 32'h0; m_mis_pend = 0; cyc = 0; last_due = -1; d2_pend = 0;
    endtask

    // One clock: drive inputs, check against the model, then advance model and memory.
    task automatic cycle_run(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
        bit    e_rv, e_ov, fire;
        int    live, lat, due;
        ent_t  e;
        infl_t f;
        mem_req_ready = rdy; out_ready = ordy; redirect_valid = redir; redirect_pc = rpc;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = memq[0].addr ^ c_XOR;
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        end
        d2_rsp_valid = d2_pend;
        #1;
        s_rv = mem_req_valid; s_addr = mem_req_addr; s_ov = out_valid;
        s_opc = out_pc; s_oistr = out_istr; s_mis = out_misalign;
        live = 0;
        foreach (m_infl[i]) if (!m_infl[i].stale) live++;
        e_rv = !redir && ((m_fifo.size() + live) < FIFO_DEPTH);
        e_ov = (m_fifo.size() > 0);
        chk("req_valid", s_rv, e_rv);
        chk("req_addr", s_addr, m_pc);
        chk("out_valid", s_ov, e_ov);
        if (e_ov) begin
            chk("out_istr", s_oistr, m_fifo[0].istr);
            chk("out_pc", s_opc, m_fifo[0].pc);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("out_misalign", s_mis, m_fifo[0].mis);
`endif
        end
        fire = s_rv && rdy;
        if (d2_req_valid) begin d2_addrs.push_back(d2_addr); d2_pend = 1; end
        else d2_pend = 0;
        @(posedge clk);
        if (mem_rsp_valid) void'(memq.pop_front());
        if (fire) begin
            lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: s_addr, due: due});
        end
        if (e_ov && ordy) void'(m_fifo.pop_front());
        if (mem_rsp_valid && m_infl.size() > 0) begin
            f = m_infl.pop_front();
            if (!f.stale && !redir) begin
                e.istr = f.pc ^ c_XOR; e.pc = f.pc; e.mis = m_mis_pend;
                m_mis_pend = 0;
                m_fifo.push_back(e);
            end
        end
        if (redir) begin
            m_fifo.delete();
            foreach (m_infl[i]) m_infl[i].stale = 1;
            m_pc = rpc & 32'hFFFF_FFFC;
            m_mis_pend = (rpc[1:0] != 2'b00);
        end else if (e_rv && rdy) begin
            m_infl.push_back('{pc: m_pc, stale: 0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic next_out(output logic [31:0] pc, output logic [31:0] istr, output logic mis);
        bit got;
        got = 0; pc = '0; istr = '0; mis = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_ov) begin got = 1; pc = s_opc; istr = s_oistr; mis = s_mis; end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL next_out_timeout: out_valid stayed 0 for 40 cycles, expected 1");
        end
    endtask

    vec_t        tbl[15];
    logic [31:0] opcs[$];
    logic [31:0] p, ins;
    logic        mis;

    initial begin
        reset = 1'b1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; out_ready = 0;
        d2_rsp_valid = 0; d2_rsp_data = 32'h13;
        rand_lat = 0; mem_lat = 1;

        // Stall then release, 1-cycle memory, ready always high.
        for (int i = 0; i < 15; i++)
            tbl[i] = '{ordy: (i >= 10), exp_rv: 0, exp_addr: 32'h8, exp_ov: 1, exp_opc: 32'h0};
        tbl[0]  = '{0, 1, 32'h0,  0, 32'h0};
        tbl[1]  = '{0, 1, 32'h4,  0, 32'h0};
        tbl[11] = '{1, 1, 32'h8,  1, 32'h4};
        tbl[12] = '{1, 1, 32'hC,  0, 32'h0};
        tbl[13] = '{1, 0, 32'h10, 1, 32'h8};
        tbl[14] = '{1, 1, 32'h10, 1, 32'hC};

        // Streaming from reset; also exercises the wrapping instance.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_ov) opcs.push_back(s_opc);
        end
        chk("stream_count", opcs.size() >= 3, 1);
        if (opcs.size() >= 3) begin
            chk("stream_pc0", opcs[0], 32'h0);
            chk("stream_pc1", opcs[1], 32'h4);
            chk("stream_pc2", opcs[2], 32'h8);
        end
        chk("wrap_count", d2_addrs.size() >= 3, 1);
        if (d2_addrs.size() >= 3) begin
            chk("wrap_addr0", d2_addrs[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", d2_addrs[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", d2_addrs[2], 32'h0000_0000);
        end

        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle_run(1'b1, tbl[i].ordy, 1'b0, 32'h0);
            chk("tbl_req_valid", s_rv, tbl[i].exp_rv);
            chk("tbl_req_addr", s_addr, tbl[i].exp_addr);
            chk("tbl_out_valid", s_ov, tbl[i].exp_ov);
            if (tbl[i].exp_ov) begin
                chk("tbl_out_pc", s_opc, tbl[i].exp_opc);
                chk("tbl_out_istr", s_oistr, tbl[i].exp_opc ^ c_XOR);
            end
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset(); mem_lat = 3;
        cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        next_out(p, ins, mis);
        chk("redir_out_pc", p, 32'h100);
        chk("redir_out_istr", ins, 32'h100 ^ c_XOR);

        // Redirect together with a response and a decode handshake.
        do_reset(); mem_lat = 1;
        cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("same_cyc_out_valid", s_ov, 1);
        chk("same_cyc_out_pc", s_opc, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_redir_req_valid", s_rv, 1);
        chk("post_redir_req_addr", s_addr, 32'h200);
        next_out(p, ins, mis);
        chk("same_cyc_next_pc", p, 32'h200);

        // Misaligned redirect target.
        do_reset();
        for (int i = 0; i < 4; i++) cycle_run(1'b1, 1'b1, 1'b0, 32'h0);
        cycle_run(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        next_out(p, ins, mis);
        chk("mis_first_pc", p, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_first_flag", mis, 1);
`endif
        next_out(p, ins, mis);
        chk("mis_second_pc", p, 32'h104);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_second_flag", mis, 0);
`endif

        // Random traffic against the reference model, with a reset mid-run.
        do_reset(); rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle_run($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 29) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
